// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame-length helper.
// Build option: define UART_PARITY_EN to add one parity bit per frame.
package uart_pkg;

    // FSM state encodings shared by the transmitter and receiver
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of bit periods in one transmitted frame
    function automatic int frame_bits(input int data_w, input int parity_bits,
                                      input int stop_bits);
        return 1 + data_w + parity_bits + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, error reporting.
// Build option: UART_PARITY_EN enables parity bit reception and checking.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT     = 16,
    parameter int PARITY_ODD       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        rx_parity_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(INPUT_DATA_WIDTH);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INPUT_DATA_WIDTH - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_bad_param
        $error("uart_rx_core: illegal CLKS_PER_BIT or PARITY_ODD");
    end

    logic [1:0]                  sync_q;
    logic                        rx_s;
    logic                        rx_prev;
    logic [2:0]                  rx_state;
    logic [CNT_W-1:0]            rx_cnt;
    logic [IDX_W-1:0]            rx_idx;
    logic [INPUT_DATA_WIDTH-1:0] rx_shift;
    logic                        frame_ok;

    assign rx_s = sync_q[1];

`ifdef UART_PARITY_EN
    logic rx_par_bit;
    logic par_bad;
    assign par_bad  = rx_par_bit ^ (^rx_shift) ^ (PARITY_ODD != 0);
    assign frame_ok = rx_s & ~par_bad;
`else
    assign frame_ok        = rx_s;
    assign rx_parity_error = 1'b0;
`endif

    // Synchronise the asynchronous line and keep the previous value for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], serial_in};
            rx_prev <= rx_s;
        end
    end

    // Receive FSM: start validation at half bit, then one sample per bit period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state        <= ST_IDLE;
            rx_cnt          <= '0;
            rx_idx          <= '0;
            rx_shift        <= '0;
            received_data   <= '0;
            data_is_valid   <= 1'b0;
            rx_error        <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bit      <= 1'b0;
            rx_parity_error <= 1'b0;
`endif
        end else begin
            data_is_valid   <= 1'b0;
            rx_error        <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_error <= 1'b0;
`endif
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s) rx_state <= ST_START;
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        // a line back high at mid start bit was only a glitch
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[INPUT_DATA_WIDTH-1:1]};
                        if (rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state <= ST_PARITY;
`else
                            rx_state <= ST_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bit <= rx_s;
                        rx_state   <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                        rx_error <= ~rx_s;
`ifdef UART_PARITY_EN
                        rx_parity_error <= par_bad;
`endif
                        if (frame_ok) begin
                            received_data <= rx_shift;
                            data_is_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_configurable.sv
// Configurable UART: inline transmitter plus uart_rx_core receiver.
// Build option: define UART_PARITY_EN to add a parity bit (PARITY_ODD selects sense).
module uart_configurable
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT     = 16,
    parameter int STOP_BITS        = 1,
    parameter int PARITY_ODD       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [INPUT_DATA_WIDTH-1:0] i_data,
    output logic                        o_busy,
    output logic                        serial_out,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        rx_parity_error
);

    localparam int FRAME_CYCLES =
        frame_bits(INPUT_DATA_WIDTH, PARITY_BITS, STOP_BITS) * CLKS_PER_BIT;
    localparam int FRAME_W = $clog2(FRAME_CYCLES);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int IDX_W   = $clog2(INPUT_DATA_WIDTH);
    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(INPUT_DATA_WIDTH - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);

    if (INPUT_DATA_WIDTH < 5 || INPUT_DATA_WIDTH > 9 || STOP_BITS < 1 || STOP_BITS > 2)
    begin : g_bad_param
        $error("uart_configurable: illegal INPUT_DATA_WIDTH or STOP_BITS");
    end

    logic [2:0]                  tx_state;
    logic [CNT_W-1:0]            tx_cnt;
    logic [IDX_W-1:0]            tx_idx;
    logic [FRAME_W-1:0]          tx_frame_cnt;
    logic [INPUT_DATA_WIDTH-1:0] tx_shift;
`ifdef UART_PARITY_EN
    logic                        tx_par;
`endif

    // Transmit FSM; the whole-frame counter alone decides when stop bits end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state     <= ST_IDLE;
            tx_cnt       <= '0;
            tx_idx       <= '0;
            tx_frame_cnt <= '0;
            tx_shift     <= '0;
            serial_out   <= 1'b1;
            o_busy       <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par       <= 1'b0;
`endif
        end else begin
            if (tx_state != ST_IDLE) tx_frame_cnt <= tx_frame_cnt + 1'b1;
            case (tx_state)
                ST_IDLE: begin
                    if (enable) begin
                        tx_shift     <= i_data;
`ifdef UART_PARITY_EN
                        tx_par       <= (^i_data) ^ (PARITY_ODD != 0);
`endif
                        tx_state     <= ST_START;
                        serial_out   <= 1'b0;
                        o_busy       <= 1'b1;
                        tx_cnt       <= '0;
                        tx_idx       <= '0;
                        tx_frame_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt     <= '0;
                        tx_state   <= ST_DATA;
                        serial_out <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state   <= ST_PARITY;
                            serial_out <= tx_par;
`else
                            tx_state   <= ST_STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            tx_idx     <= tx_idx + 1'b1;
                            serial_out <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt     <= '0;
                        tx_state   <= ST_STOP;
                        serial_out <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tx_frame_cnt == FRAME_LAST) begin
                        tx_state <= ST_IDLE;
                        o_busy   <= 1'b0;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_core #(
        .INPUT_DATA_WIDTH(INPUT_DATA_WIDTH),
        .CLKS_PER_BIT    (CLKS_PER_BIT),
        .PARITY_ODD      (PARITY_ODD)
    ) u_rx (
        .clk            (clk),
        .reset          (reset),
        .serial_in      (serial_in),
        .received_data  (received_data),
        .data_is_valid  (data_is_valid),
        .rx_error       (rx_error),
        .rx_parity_error(rx_parity_error)
    );

endmodule

// File: doc/uart_configurable.md
UART_CONFIGURABLE -- requirements
Module: uart_configurable

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, minimum 4, even values only.
REQ-003 Parameter STOP_BITS, default 1: stop bits per transmitted frame, 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored without PARITY_EN.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  transmit request; accepted only when o_busy is low.
REQ-008 i_data  input  INPUT_DATA_WIDTH  transmit data, sampled on the accepting cycle.
REQ-009 o_busy  output  1  transmitter frame in progress.
REQ-010 serial_out  output  1  TX line, idle high.
REQ-011 serial_in  input  1  RX line, asynchronous to clk, idle high.
REQ-012 received_data  output  INPUT_DATA_WIDTH  last correctly received word.
REQ-013 data_is_valid  output  1  one-cycle pulse: received_data updated.
REQ-014 rx_error  output  1  one-cycle pulse: framing error (stop bit sampled low).
REQ-015 rx_parity_error  output  1  one-cycle pulse: parity mismatch; constant 0 without PARITY_EN.

Function
REQ-016 TX FSM states: IDLE, START, DATA, PARITY, STOP; RX FSM has the same five states.
REQ-017 enable high while in IDLE shall latch i_data and enter START; serial_out goes low and o_busy goes high on the next cycle.
REQ-018 enable while o_busy is high shall be ignored, with no queuing.
REQ-019 Every bit shall be held for exactly CLKS_PER_BIT cycles; data is sent LSB first.
REQ-020 PARITY state shall be entered only with PARITY_EN.
REQ-021 STOP shall drive serial_out high for STOP_BITS*CLKS_PER_BIT cycles; o_busy falls on the cycle after the last stop-bit cycle.
REQ-022 Total o_busy duration shall be (1+INPUT_DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with PARITY_EN and 0 otherwise.
REQ-023 A new frame may be accepted on the first cycle o_busy is low; there are no gap cycles between frames.
REQ-024 serial_in shall pass through a 2-flop synchroniser before any use.
REQ-025 RX IDLE->START on a synchronised high-to-low edge; the line is re-sampled CLKS_PER_BIT/2 cycles later, and if high (glitch) RX returns to IDLE with no output pulse.
REQ-026 Data and parity bits shall be sampled at mid-bit, CLKS_PER_BIT cycles apart; samples are shifted LSB first.
REQ-027 RX shall check exactly one stop bit, regardless of STOP_BITS.
REQ-028 At the stop-bit sample: low -> rx_error pulse; parity mismatch -> rx_parity_error pulse; otherwise received_data is updated with a data_is_valid pulse in the same cycle.
REQ-029 received_data shall be unchanged on any error, and data_is_valid shall never coincide with either error pulse; if the stop bit is low and parity also mismatches, both error pulses fire together.
REQ-030 After the stop sample, RX returns to IDLE immediately, ready for the next start edge.
REQ-031 TX and RX shall operate fully independently and concurrently.

Reset
REQ-032 reset shall force, asynchronously: serial_out=1, o_busy=0, data_is_valid=0, rx_error=0, rx_parity_error=0, received_data=0, both FSMs to IDLE, all counters to 0, synchroniser flops to 1.
REQ-033 Reset mid-frame shall abort the frame with no completion pulse; a partial RX frame is discarded.

Configuration
REQ-034 Macro UART_PARITY_EN: when defined, one parity bit (per PARITY_ODD) is sent after the data bits, checked on receive, and reported on rx_parity_error; when undefined, there is no parity bit, no parity logic, and rx_parity_error is tied 0.

Structure
REQ-035 Package uart_pkg shall hold the FSM state encodings and a frame-length helper constant function.
REQ-036 The receiver shall be the sub-module uart_rx_core (synchroniser, RX FSM, sampling counter); the transmitter shall be inline.

Verification (INPUT_DATA_WIDTH=8, CLKS_PER_BIT=16, STOP_BITS=1, serial_in looped to serial_out)
REQ-037 enable with i_data=0xA5, no parity -> start bit low for 16 cycles, bits 1,0,1,0,0,1,0,1, o_busy high for 160 cycles, one data_is_valid pulse with received_data=0xA5, no error pulses.
REQ-038 enable=1 with i_data=0x3C during a busy 0xA5 frame -> ignored; only 0xA5 is received.
REQ-039 UART_PARITY_EN, even parity, 0x07 -> parity bit 1; the same frame injected with parity bit 0 -> rx_parity_error pulse, no data_is_valid, received_data unchanged.
REQ-040 serial_in held low through the stop-bit sample -> rx_error pulse, no data_is_valid.
REQ-041 A 4-cycle low glitch on idle serial_in -> no pulse on any RX output, RX back in IDLE.
REQ-042 reset asserted at cycle 50 of a frame -> serial_out=1 and o_busy=0 without waiting for a clk edge; no data_is_valid; the next frame (0x5A) is received correctly.
